// File: rtl/pc_sequencer.sv
// Program-counter stage: holds PC and the supervisor bit, selects the next PC, latches
// interrupt requests into a pending level, and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  PCSEL,
    input  logic [15:0] C_LITERAL,
    input  logic [31:0] JT,
    input  logic        STALL,
    input  logic        IRQ_REQ,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        PC_31,
    output logic        IRQ,
    output logic [31:0] INSTR_COUNT
);

    logic [31:0] pc_q;
    logic        irq_q;
    logic [31:0] count_q;
    logic [31:0] next_pc;
    logic [30:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        retire;

    assign retire = RESET_N && !STALL;

    // The increment stays inside the low 31 bits so the supervisor bit never flips.
    assign PC_PLUS4 = {pc_q[31], pc_q[30:0] + 31'd4};

    assign branch_offset = {{13{C_LITERAL[15]}}, C_LITERAL, 2'b00};
    assign branch_target = {pc_q[31], PC_PLUS4[30:0] + branch_offset};

    // A jump may drop supervisor mode but never gain it; low target bits are ignored.
    assign jump_target = {pc_q[31] & JT[31], JT[30:0] & 31'h7FFF_FFFC};

    always_comb begin
        next_pc = ILLOP_ADDR;
        case (PCSEL)
            3'd0:    next_pc = PC_PLUS4;
            3'd1:    next_pc = branch_target;
            3'd2:    next_pc = jump_target;
            3'd3:    next_pc = ILLOP_ADDR;
            3'd4:    next_pc = XADR_ADDR;
            default: next_pc = ILLOP_ADDR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            pc_q    <= RESET_ADDR;
            count_q <= 32'd0;
        end else if (retire) begin
            pc_q    <= next_pc;
            count_q <= count_q + 32'd1;
        end
    end

    // A new request on the same edge as the vector taken wins over the clear.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            irq_q <= 1'b0;
        end else if (IRQ_REQ) begin
            irq_q <= 1'b1;
        end else if (retire && PCSEL == 3'd4) begin
            irq_q <= 1'b0;
        end
    end

    assign PC          = pc_q;
    assign PC_31       = pc_q[31];
    assign IRQ         = irq_q;
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each clock edge of stimulus queues its expected
// {PC, IRQ, INSTR_COUNT}; a monitor pops and compares after every rising edge.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic [2:0]  PCSEL;
    logic [15:0] C_LITERAL;
    logic [31:0] JT;
    logic        STALL;
    logic        IRQ_REQ;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        PC_31;
    logic        IRQ;
    logic [31:0] INSTR_COUNT;

    logic [64:0] exp_q[$];
    int          checks;
    int          errors;

    pc_sequencer dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .PCSEL(PCSEL),
        .C_LITERAL(C_LITERAL),
        .JT(JT),
        .STALL(STALL),
        .IRQ_REQ(IRQ_REQ),
        .PC(PC),
        .PC_PLUS4(PC_PLUS4),
        .PC_31(PC_31),
        .IRQ(IRQ),
        .INSTR_COUNT(INSTR_COUNT)
    );

    // Clock and reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one edge worth of inputs and queue what the DUT must show after that edge.
    task automatic step(input logic rst_n, input logic stall, input logic [2:0] sel,
                        input logic [15:0] lit, input logic [31:0] jt, input logic req,
                        input logic [31:0] e_pc, input logic e_irq, input logic [31:0] e_cnt);
        @(negedge CLK);
        RESET_N   = rst_n;
        STALL     = stall;
        PCSEL     = sel;
        C_LITERAL = lit;
        JT        = jt;
        IRQ_REQ   = req;
        exp_q.push_back({e_pc, e_irq, e_cnt});
    endtask

    // Scoreboard monitor
    always begin
        logic [64:0] e;
        logic [31:0] e_pc;
        logic [31:0] e_plus4;
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            e       = exp_q.pop_front();
            e_pc    = e[64:33];
            e_plus4 = {e_pc[31], e_pc[30:0] + 31'd4};
            check("pc", PC, e_pc);
            check("pc_plus4", PC_PLUS4, e_plus4);
            check("pc_31", {31'd0, PC_31}, {31'd0, e_pc[31]});
            check("irq", {31'd0, IRQ}, {31'd0, e[32]});
            check("instr_count", INSTR_COUNT, e[31:0]);
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        RESET_N   = 1'b0;
        STALL     = 1'b0;
        PCSEL     = 3'd0;
        C_LITERAL = 16'h0000;
        JT        = 32'h0;
        IRQ_REQ   = 1'b0;

        // reset and sequential fetch, stall hold
        step(0, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_0000, 0, 32'd0);
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_0004, 0, 32'd1);
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_0008, 0, 32'd2);
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_000C, 0, 32'd3);
        step(1, 1, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_000C, 0, 32'd3);
        // branches in user mode, and the 7FFF_FFFC +4 wrap
        step(1, 0, 3'd2, 16'h0000, 32'h0000_0100, 0, 32'h0000_0100, 0, 32'd4);
        step(1, 0, 3'd1, 16'hFFFE, 32'h0,         0, 32'h0000_00FC, 0, 32'd5);
        step(1, 0, 3'd2, 16'h0000, 32'h0000_0100, 0, 32'h0000_0100, 0, 32'd6);
        step(1, 0, 3'd1, 16'h0003, 32'h0,         0, 32'h0000_0110, 0, 32'd7);
        step(1, 0, 3'd2, 16'h0000, 32'h7FFF_FFFC, 0, 32'h7FFF_FFFC, 0, 32'd8);
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h0000_0000, 0, 32'd9);
        // jumps: no privilege gain from user, drop from supervisor
        step(1, 0, 3'd2, 16'h0000, 32'h0000_0040, 0, 32'h0000_0040, 0, 32'd10);
        step(1, 0, 3'd2, 16'h0000, 32'h8000_1237, 0, 32'h0000_1234, 0, 32'd11);
        step(0, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_0000, 0, 32'd0);
        step(1, 0, 3'd2, 16'h0000, 32'h8000_0040, 0, 32'h8000_0040, 0, 32'd1);
        step(1, 0, 3'd2, 16'h0000, 32'h0000_2000, 0, 32'h0000_2000, 0, 32'd2);
        // interrupts: set during stall, clear on vector, set-wins, reset drops pending
        step(1, 1, 3'd4, 16'h0000, 32'h0,         1, 32'h0000_2000, 1, 32'd2);
        step(1, 0, 3'd4, 16'h0000, 32'h0,         0, 32'h8000_0008, 0, 32'd3);
        step(1, 1, 3'd0, 16'h0000, 32'h0,         1, 32'h8000_0008, 1, 32'd3);
        step(1, 0, 3'd4, 16'h0000, 32'h0,         1, 32'h8000_0008, 1, 32'd4);
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'h8000_000C, 1, 32'd5);
        step(0, 1, 3'd4, 16'h0000, 32'h0,         1, 32'h8000_0000, 0, 32'd0);
        // reserved selects fall back to ILLOP
        step(1, 0, 3'd6, 16'h0000, 32'h0,         0, 32'h8000_0004, 0, 32'd1);
        step(1, 0, 3'd5, 16'h0000, 32'h0,         0, 32'h8000_0004, 0, 32'd2);
        step(1, 0, 3'd7, 16'h0000, 32'h0,         0, 32'h8000_0004, 0, 32'd3);
        step(1, 0, 3'd3, 16'h0000, 32'h0,         0, 32'h8000_0004, 0, 32'd4);
        // supervisor branches keep PC[31]; large negative offset wraps mod 2^31
        step(1, 0, 3'd1, 16'h0001, 32'h0,         0, 32'h8000_000C, 0, 32'd5);
        step(1, 0, 3'd1, 16'h8000, 32'h0,         0, 32'hFFFE_0010, 0, 32'd6);

        // retired-count wrap from a forced all-ones value
        @(negedge CLK);
        RESET_N   = 1'b1;
        STALL     = 1'b0;
        PCSEL     = 3'd0;
        C_LITERAL = 16'h0000;
        JT        = 32'h0;
        IRQ_REQ   = 1'b0;
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        exp_q.push_back({32'hFFFE_0014, 1'b0, 32'd0});
        step(1, 0, 3'd0, 16'h0000, 32'h0,         0, 32'hFFFE_0018, 0, 32'd1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, wanted 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
